id_ex_issue: RTL and testbench

//  ID/EX pipeline register and operand-issue stage directly upstream of the ALU.

---
 rtl/id_ex_issue_pkg.sv | 26 ++
 rtl/id_ex_issue_if.sv | 33 +++
 rtl/id_ex_issue_alu_code_decode.sv | 36 +++
 rtl/id_ex_issue.sv | 120 ++++++++++++
 tb/tb_id_ex_issue.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_issue_pkg.sv
// rtl/id_ex_issue_pkg.sv - ALU codes, ALUOp encodings and funct constants for the issue stage
package id_ex_issue_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SGT = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ORI    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;

endpackage

// File: rtl/id_ex_issue_if.sv
// rtl/id_ex_issue_if.sv - decode-to-issue handshake and decoded instruction fields
interface id_ex_issue_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic              id_ready;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [XLEN-1:0]   id_rs_data;
    logic [XLEN-1:0]   id_rt_data;
    logic [15:0]       id_imm;
    logic [4:0]        id_shamt;
    logic [1:0]        id_alu_op;
    logic [5:0]        id_funct;
    logic              id_alu_src;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_alu_op, id_funct, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_alu_op, id_funct, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
        output id_ready
    );
endinterface

// File: rtl/id_ex_issue_alu_code_decode.sv
// rtl/id_ex_issue_alu_code_decode.sv - ALUOp/funct to ALU code, operand-swap and shift selects
module alu_code_decode
    import id_ex_issue_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] code,
    output logic       swap,
    output logic       shift_sel,
    output logic       illegal
);
    always_comb begin
        code      = ALU_NOP;
        swap      = 1'b0;
        shift_sel = 1'b0;
        illegal   = 1'b0;
        case (alu_op)
            ALUOP_MEM:    code = ALU_ADD;
            ALUOP_BRANCH: code = ALU_SUB;
            ALUOP_ORI:    code = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: code = ALU_ADD;
                    FUNCT_SUB: code = ALU_SUB;
                    FUNCT_AND: code = ALU_AND;
                    FUNCT_OR:  code = ALU_OR;
                    // rs<rt is computed as rt>rs on the ALU's greater-than unit
                    FUNCT_SLT: begin code = ALU_SGT; swap = 1'b1; end
                    FUNCT_SLL: begin code = ALU_SLL; shift_sel = 1'b1; end
                    FUNCT_SRL: begin code = ALU_SRL; shift_sel = 1'b1; end
                    default:   illegal = 1'b1;
                endcase
            end
        endcase
    end
endmodule

// File: rtl/id_ex_issue.sv
// rtl/id_ex_issue.sv - ID/EX register with operand forwarding and load-use hazard stall
module id_ex_issue
    import id_ex_issue_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    id_ex_issue_if.slave      id,
    input  logic              fl_flush,
    input  logic              ex_ready,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [XLEN-1:0]   memwb_result,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_code,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [XLEN-1:0]   ex_store_data,
    output logic              ex_illegal
);
    logic [3:0]        dec_code;
    logic              dec_swap, dec_shift, dec_illegal;
    logic              uses_rt, hazard, hold, load;
    logic [REG_AW-1:0] rs_idx, rt_idx;
    logic [XLEN-1:0]   rs_data, rt_data, imm_ext, rs_fwd, rt_fwd, id_imm_ext;
    logic [4:0]        shamt;
    logic              swap, shift_sel, alu_src;

    alu_code_decode u_dec (
        .alu_op    (id.id_alu_op),
        .funct     (id.id_funct),
        .code      (dec_code),
        .swap      (dec_swap),
        .shift_sel (dec_shift),
        .illegal   (dec_illegal)
    );

    assign uses_rt = (id.id_alu_op == ALUOP_RTYPE) | id.id_mem_write | (id.id_alu_op == ALUOP_BRANCH);
    assign hazard  = ex_valid & ex_mem_read & (ex_rd != '0) &
                     ((ex_rd == id.id_rs) | (uses_rt & (ex_rd == id.id_rt)));
    assign hold        = ex_valid & ~ex_ready;
    assign id.id_ready = ~fl_flush & ~hazard & (~ex_valid | ex_ready);
    assign load        = id.id_valid & id.id_ready;
    assign id_imm_ext  = (id.id_alu_op == ALUOP_ORI) ? {{(XLEN-16){1'b0}}, id.id_imm}
                                                     : {{(XLEN-16){id.id_imm[15]}}, id.id_imm};

    // Flush, reset and an idle/stalled slot all collapse to the same bubble contents
    always_ff @(posedge clk) begin
        if (rst || fl_flush || !(hold || load)) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            rs_idx       <= '0;
            rt_idx       <= '0;
            rs_data      <= '0;
            rt_data      <= '0;
            imm_ext      <= '0;
            shamt        <= '0;
            alu_code     <= ALU_NOP;
            swap         <= 1'b0;
            shift_sel    <= 1'b0;
            alu_src      <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (load) begin
            ex_valid     <= 1'b1;
            ex_rd        <= id.id_rd;
            rs_idx       <= id.id_rs;
            rt_idx       <= id.id_rt;
            rs_data      <= id.id_rs_data;
            rt_data      <= id.id_rt_data;
            imm_ext      <= id_imm_ext;
            shamt        <= id.id_shamt;
            alu_code     <= dec_code;
            swap         <= dec_swap;
            shift_sel    <= dec_shift;
            alu_src      <= id.id_alu_src;
            ex_reg_write <= id.id_reg_write & ~dec_illegal;
            ex_mem_read  <= id.id_mem_read;
            ex_mem_write <= id.id_mem_write;
            ex_illegal   <= dec_illegal;
        end
    end

    function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] idx,
                                            input logic [XLEN-1:0]   data,
                                            input logic              em_we,
                                            input logic [REG_AW-1:0] em_rd,
                                            input logic [XLEN-1:0]   em_res,
                                            input logic              mw_we,
                                            input logic [REG_AW-1:0] mw_rd,
                                            input logic [XLEN-1:0]   mw_res);
        if (idx != '0 && em_we && em_rd == idx) return em_res;
        if (idx != '0 && mw_we && mw_rd == idx) return mw_res;
        return data;
    endfunction

    always_comb begin
        rs_fwd = fwd(rs_idx, rs_data, exmem_reg_write, exmem_rd, exmem_result,
                     memwb_reg_write, memwb_rd, memwb_result);
        rt_fwd = fwd(rt_idx, rt_data, exmem_reg_write, exmem_rd, exmem_result,
                     memwb_reg_write, memwb_rd, memwb_result);
        alu_a  = (swap || shift_sel) ? rt_fwd : rs_fwd;
        if (shift_sel)    alu_b = {{(XLEN-5){1'b0}}, shamt};
        else if (swap)    alu_b = rs_fwd;
        else if (alu_src) alu_b = imm_ext;
        else              alu_b = rt_fwd;
        ex_store_data = rt_fwd;
    end
endmodule

// File: tb/tb_id_ex_issue.sv
// tb/tb_id_ex_issue.sv - directed self-checking bench for id_ex_issue
module tb_id_ex_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic        fl_flush, ex_ready;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_code;
    logic [4:0]  ex_rd;
    int          total = 0;
    int          passed = 0;

    id_ex_issue_if bus ();

    id_ex_issue dut (
        .clk             (clk),
        .rst             (rst),
        .id              (bus),
        .fl_flush        (fl_flush),
        .ex_ready        (ex_ready),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .ex_valid        (ex_valid),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_code        (alu_code),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_store_data   (ex_store_data),
        .ex_illegal      (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [1:0] op, input logic [5:0] funct, input logic src,
                         input logic [15:0] imm, input logic [4:0] sh,
                         input logic rw, input logic mr, input logic mw);
        bus.id_valid = 1'b1;  bus.id_rs = rs;  bus.id_rt = rt;  bus.id_rd = rd;
        bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_alu_op = op; bus.id_funct = funct;
        bus.id_alu_src = src; bus.id_imm = imm; bus.id_shamt = sh;
        bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    initial begin
        rst = 1; fl_flush = 0; ex_ready = 1;
        no_fwd();
        instr(0, 0, 0, 0, 0, 2'b00, 6'd0, 0, 16'd0, 5'd0, 0, 0, 0);
        bus.id_valid = 0;
        tick(); tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_code", alu_code, 4'hF);
        chk("rst_rd", ex_rd, 0);
        chk("rst_rw", ex_reg_write, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_illegal", ex_illegal, 0);
        rst = 0;
        #1 chk("rst_ready", bus.id_ready, 1);

        // add $3,$1,$2 with 5 and 7
        instr(1, 2, 3, 5, 7, 2'b10, 6'b100000, 0, 16'd0, 5'd0, 1, 0, 0);
        tick(); bus.id_valid = 0;
        chk("add_code", alu_code, 4'b0010);
        chk("add_a", alu_a, 5);
        chk("add_b", alu_b, 7);
        chk("add_rd", ex_rd, 3);
        chk("add_valid", ex_valid, 1);
        chk("add_rw", ex_reg_write, 1);

        instr(4, 5, 6, 2, 9, 2'b10, 6'b101010, 0, 16'd0, 5'd0, 1, 0, 0);
        tick(); bus.id_valid = 0;
        chk("slt_code", alu_code, 4'b1000);
        chk("slt_a", alu_a, 9);
        chk("slt_b", alu_b, 2);

        instr(0, 5, 6, 0, 1, 2'b10, 6'b000000, 0, 16'd0, 5'd4, 1, 0, 0);
        tick(); bus.id_valid = 0;
        chk("sll_code", alu_code, 4'b0011);
        chk("sll_a", alu_a, 1);
        chk("sll_b", alu_b, 4);

        instr(0, 5, 6, 0, 32'h80, 2'b10, 6'b000010, 0, 16'd0, 5'd31, 1, 0, 0);
        tick(); bus.id_valid = 0;
        chk("srl_code", alu_code, 4'b1100);
        chk("srl_b", alu_b, 31);

        instr(1, 2, 3, 32'h11, 32'h22, 2'b10, 6'b100000, 0, 16'd0, 5'd0, 1, 0, 0);
        exmem_reg_write = 1; exmem_rd = 1; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 1; memwb_result = 32'hBB;
        tick(); bus.id_valid = 0;
        chk("fwd_exmem_wins", alu_a, 32'hAA);
        chk("fwd_b_none", alu_b, 32'h22);
        exmem_reg_write = 0;
        #1 chk("fwd_memwb", alu_a, 32'hBB);
        memwb_rd = 2;
        #1 chk("fwd_memwb_b", alu_b, 32'hBB);
        chk("fwd_store", ex_store_data, 32'hBB);
        chk("fwd_a_reg", alu_a, 32'h11);

        instr(0, 2, 3, 32'h33, 32'h44, 2'b10, 6'b100000, 0, 16'd0, 5'd0, 1, 0, 0);
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hAA;
        tick(); bus.id_valid = 0;
        chk("fwd_idx0", alu_a, 32'h33);
        no_fwd();

        // sign- vs zero-extended immediates; forwarding must not touch imm
        instr(1, 2, 2, 32'd10, 32'h55, 2'b00, 6'd0, 1, 16'hFFFF, 5'd0, 1, 0, 0);
        memwb_reg_write = 1; memwb_rd = 2; memwb_result = 32'hCC;
        tick(); bus.id_valid = 0;
        chk("addi_code", alu_code, 4'b0010);
        chk("addi_b", alu_b, 32'hFFFFFFFF);
        no_fwd();
        instr(1, 2, 2, 32'd10, 32'h55, 2'b11, 6'd0, 1, 16'hFFFF, 5'd0, 1, 0, 0);
        tick(); bus.id_valid = 0;
        chk("ori_code", alu_code, 4'b0001);
        chk("ori_b", alu_b, 32'h0000FFFF);

        // lw $4 followed by dependent add
        instr(1, 0, 4, 32'h100, 0, 2'b00, 6'd0, 1, 16'd4, 5'd0, 1, 1, 0);
        tick();
        chk("lw_mr", ex_mem_read, 1);
        instr(4, 2, 5, 32'h0, 32'h3, 2'b10, 6'b100000, 0, 16'd0, 5'd0, 1, 0, 0);
        #1 chk("haz_ready", bus.id_ready, 0);
        tick();
        chk("haz_bubble_valid", ex_valid, 0);
        chk("haz_bubble_code", alu_code, 4'hF);
        chk("haz_ready_after", bus.id_ready, 1);
        memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'h77;
        tick(); bus.id_valid = 0;
        chk("haz_accept_valid", ex_valid, 1);
        chk("haz_accept_rd", ex_rd, 5);
        chk("haz_memwb_a", alu_a, 32'h77);
        no_fwd();

        // hold for three cycles, then flush during hold
        instr(1, 2, 3, 5, 7, 2'b10, 6'b100000, 0, 16'd0, 5'd0, 1, 0, 0);
        tick();
        ex_ready = 0;
        instr(6, 7, 9, 32'h66, 32'h77, 2'b10, 6'b100010, 0, 16'd0, 5'd0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_ready", bus.id_ready, 0);
            tick();
            chk("hold_valid", ex_valid, 1);
            chk("hold_code", alu_code, 4'b0010);
            chk("hold_rd", ex_rd, 3);
            chk("hold_a", alu_a, 5);
            chk("hold_b", alu_b, 7);
        end
        fl_flush = 1;
        #1 chk("flush_ready", bus.id_ready, 0);
        tick();
        chk("flush_valid", ex_valid, 0);
        chk("flush_code", alu_code, 4'hF);
        fl_flush = 0; ex_ready = 1; bus.id_valid = 0;

        instr(1, 2, 3, 5, 7, 2'b10, 6'b111111, 0, 16'd0, 5'd0, 1, 0, 0);
        tick(); bus.id_valid = 0;
        chk("ill_flag", ex_illegal, 1);
        chk("ill_code", alu_code, 4'hF);
        chk("ill_rw", ex_reg_write, 0);
        chk("ill_valid", ex_valid, 1);

        instr(1, 2, 3, 5, 7, 2'b10, 6'b100000, 0, 16'd0, 5'd0, 1, 0, 0);
        tick();
        chk("pre_rst_valid", ex_valid, 1);
        rst = 1;
        tick();
        chk("mid_rst_valid", ex_valid, 0);
        chk("mid_rst_rd", ex_rd, 0);
        chk("mid_rst_code", alu_code, 4'hF);
        rst = 0; bus.id_valid = 0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
